// File: rtl/mera_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, timeout default,
// and the instruction-format helper used to detect two-word instructions.
package mera_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_OP  = 3'd1,
    S_LOAD_IR   = 3'd2,
    S_FETCH_ARG = 3'd3,
    S_DONE      = 3'd4
  } ifetch_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int TO_W = 5;

  // Word bits are numbered MSB-first (bit 0 = MSB), so the C field 13..15 is [2:0] here.
  function automatic logic is_two_word(input logic [15:0] word);
    return word[2:0] == 3'b000;
  endfunction

endpackage

// File: rtl/bus_timeout.sv
// Bus request watchdog: counts cycles a request waits unanswered and flags
// the cycle in which the TIMEOUT_CYCLES-th unanswered cycle occurs.
module bus_timeout
  import mera_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk_sys) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expires during the last unanswered cycle so the requester can drop mem_req at its end.
  assign expired = run && (r_count == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: reads the opcode word (and an argument word for C=0),
// strobes the instruction register, reports ic_out. Optional prefetch: IFETCH_PREFETCH_EN.
module ifetch
  import mera_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   ic_in,
  input  logic [3:0]    nb_in,
  input  logic          flush,
  output logic          mem_req,
  output logic [15:0]   mem_addr,
  output logic [3:0]    mem_nb,
  input  logic          mem_ok,
  input  logic [15:0]   mem_data,
  output logic [15:0]   w,
  output logic          w_ir,
  output logic          strob1,
  output logic [15:0]   arg,
  output logic          arg_valid,
  output logic [15:0]   ic_out,
  output logic          busy,
  output logic          done,
  output logic          alarm,
  output ifetch_state_t dbg_state
);

  ifetch_state_t r_state;
  logic [15:0]   r_ic, r_mem_addr, r_w, r_arg, r_ic_out;
  logic [3:0]    r_nb;
  logic          r_mem_req, r_ir, r_arg_valid, r_done, r_alarm;
  logic          w_ok, w_expired;

`ifdef IFETCH_PREFETCH_EN
  logic          r_pf_active, r_pf_valid;
  logic [15:0]   r_pf_addr, r_pf_data;
  logic [3:0]    r_pf_nb;
`else
  logic          w_unused;
  assign w_unused = flush;
`endif

  // mem_ok only counts while a request is actually on the bus.
  assign w_ok = r_mem_req && mem_ok;

  bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_sys (clk_sys),
    .rst     (rst),
    .run     (r_mem_req && !mem_ok),
    .clear   (!r_mem_req),
    .expired (w_expired)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ic        <= '0;
      r_nb        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_w         <= '0;
      r_ir        <= 1'b0;
      r_arg       <= '0;
      r_arg_valid <= 1'b0;
      r_ic_out    <= '0;
      r_done      <= 1'b0;
      r_alarm     <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
      r_pf_active <= 1'b0;
      r_pf_valid  <= 1'b0;
      r_pf_addr   <= '0;
      r_pf_data   <= '0;
      r_pf_nb     <= '0;
`endif
    end else begin
      r_ir   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef IFETCH_PREFETCH_EN
          if (flush) begin
            r_pf_valid  <= 1'b0;
            r_pf_active <= 1'b0;
            r_mem_req   <= 1'b0;
          end else if (r_pf_active && !start) begin
            if (w_ok) begin
              r_pf_data   <= mem_data;
              r_pf_valid  <= 1'b1;
              r_pf_active <= 1'b0;
              r_mem_req   <= 1'b0;
            end else if (w_expired) begin
              r_pf_active <= 1'b0;
              r_mem_req   <= 1'b0;
            end
          end
`endif
          if (start) begin
            r_ic        <= ic_in;
            r_nb        <= nb_in;
            r_mem_addr  <= ic_in;
            r_alarm     <= 1'b0;
            r_arg_valid <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            r_pf_valid  <= 1'b0;
            r_pf_active <= 1'b0;
            if (r_pf_valid && !flush && ic_in == r_pf_addr && nb_in == r_pf_nb) begin
              r_w       <= r_pf_data;
              r_ir      <= 1'b1;
              r_mem_req <= 1'b0;
              r_state   <= S_LOAD_IR;
            end else begin
              // An aborted prefetch leaves the bus idle for one cycle before the real request.
              r_mem_req <= !r_pf_active;
              r_state   <= S_FETCH_OP;
            end
`else
            r_mem_req   <= 1'b1;
            r_state     <= S_FETCH_OP;
`endif
          end
        end
        S_FETCH_OP: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (w_ok) begin
            r_w       <= mem_data;
            r_ir      <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_LOAD_IR;
          end else if (w_expired) begin
            r_mem_req <= 1'b0;
            r_alarm   <= 1'b1;
            r_done    <= 1'b1;
            r_ic_out  <= r_ic;
            r_state   <= S_DONE;
          end
        end
        S_LOAD_IR: begin
          r_ic <= r_ic + 16'd1;
          if (is_two_word(r_w)) begin
            r_mem_addr <= r_ic + 16'd1;
            r_mem_req  <= 1'b1;
            r_state    <= S_FETCH_ARG;
          end else begin
            r_done   <= 1'b1;
            r_ic_out <= r_ic + 16'd1;
            r_state  <= S_DONE;
          end
        end
        S_FETCH_ARG: begin
          if (w_ok) begin
            r_arg       <= mem_data;
            r_arg_valid <= 1'b1;
            r_ic        <= r_ic + 16'd1;
            r_mem_req   <= 1'b0;
            r_done      <= 1'b1;
            r_ic_out    <= r_ic + 16'd1;
            r_state     <= S_DONE;
          end else if (w_expired) begin
            r_mem_req <= 1'b0;
            r_alarm   <= 1'b1;
            r_done    <= 1'b1;
            r_ic_out  <= r_ic;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef IFETCH_PREFETCH_EN
          if (!r_alarm) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= r_ic;
            r_pf_active <= 1'b1;
            r_pf_addr   <= r_ic;
            r_pf_nb     <= r_nb;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_nb    = r_nb;
  assign w         = r_w;
  assign w_ir      = r_ir;
  assign strob1    = r_ir;
  assign arg       = r_arg;
  assign arg_valid = r_arg_valid;
  assign ic_out    = r_ic_out;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign alarm     = r_alarm;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed cases plus randomized fetches against a
// transaction-level model of the expected bus requests, timing and results.
module tb_ifetch;
  import mera_pkg::*;

  localparam int T = 16;

  logic          clk_sys = 1'b0;
  logic          rst, start, flush, mem_ok;
  logic [15:0]   ic_in, mem_data;
  logic [3:0]    nb_in;
  logic          mem_req, w_ir, strob1, arg_valid, busy, done, alarm;
  logic [15:0]   mem_addr, w, arg, ic_out;
  logic [3:0]    mem_nb;
  ifetch_state_t dbg_state;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  ifetch #(.TIMEOUT_CYCLES(T)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .start     (start),
    .ic_in     (ic_in),
    .nb_in     (nb_in),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_nb    (mem_nb),
    .mem_ok    (mem_ok),
    .mem_data  (mem_data),
    .w         (w),
    .w_ir      (w_ir),
    .strob1    (strob1),
    .arg       (arg),
    .arg_valid (arg_valid),
    .ic_out    (ic_out),
    .busy      (busy),
    .done      (done),
    .alarm     (alarm),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, 32'({mem_req, w_ir, strob1, arg_valid, busy, done, alarm}), 32'd0);
    check({tag, "_w"}, 32'(w), 32'd0);
    check({tag, "_arg"}, 32'(arg), 32'd0);
    check({tag, "_ic_out"}, 32'(ic_out), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_nb"}, 32'(mem_nb), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // One fetch transaction. lat0/lat1: unanswered request cycles before mem_ok (-1 = never).
  // Returns at the negedge of the done cycle.
  task automatic do_fetch(input logic [15:0] ic, input logic [3:0] nb, input logic [15:0] d0,
                          input logic [15:0] d1, input int lat0, input int lat1, input bit noise);
    bit two, op_ok, arg_ok, exp_alarm, exp_av, finished, prev_req;
    int exp_edges, exp_req_cycles, exp_wir, edges, req_cycles, wir, req_idx, wait_n, lat;
    logic [15:0] a1, a2, exp_ic_out;
    two    = (d0[2:0] == 3'b000);
    op_ok  = (lat0 >= 0);
    arg_ok = (lat1 >= 0);
    a1 = ic + 16'd1;
    a2 = ic + 16'd2;
    exp_q.delete();
    exp_q.push_back(ic);
    if (!op_ok) begin
      exp_edges = 1 + T; exp_req_cycles = T; exp_wir = 0;
      exp_ic_out = ic; exp_alarm = 1'b1; exp_av = 1'b0;
    end else if (!two) begin
      exp_edges = lat0 + 3; exp_req_cycles = lat0 + 1; exp_wir = 1;
      exp_ic_out = a1; exp_alarm = 1'b0; exp_av = 1'b0;
    end else begin
      exp_q.push_back(a1);
      exp_edges = lat0 + 3 + (arg_ok ? lat1 + 1 : T);
      exp_req_cycles = lat0 + 1 + (arg_ok ? lat1 + 1 : T);
      exp_wir = 1;
      exp_ic_out = arg_ok ? a2 : a1;
      exp_alarm = !arg_ok; exp_av = arg_ok;
    end

    @(negedge clk_sys);
    start = 1'b1; ic_in = ic; nb_in = nb; mem_ok = 1'b0;
    @(negedge clk_sys);
    start = 1'b0;
    edges = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    check("alarm_cleared", 32'(alarm), 32'd0);
    check("argv_cleared", 32'(arg_valid), 32'd0);
    req_idx = -1; wait_n = 0; prev_req = 1'b0; req_cycles = 0; wir = 0; finished = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      if (w_ir) begin
        wir++;
        check("w", 32'(w), 32'(d0));
        check("strob1", 32'(strob1), 32'd1);
      end
      if (done) begin
        finished = 1'b1;
      end else begin
        if (mem_req) begin
          if (!prev_req) begin
            req_idx++;
            wait_n = 0;
            if (exp_q.size() == 0) check("extra_req", 32'(mem_addr), 32'hFFFF_FFFF);
            else check("req_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
            check("mem_nb", 32'(mem_nb), 32'(nb));
          end
          req_cycles++;
          lat = (req_idx == 0) ? lat0 : lat1;
          mem_ok = (wait_n == lat);
          mem_data = mem_ok ? ((req_idx == 0) ? d0 : d1) : 16'($urandom);
          wait_n++;
        end else begin
          mem_ok = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          mem_data = 16'($urandom);
        end
        prev_req = mem_req;
        if (noise) begin
          start = ($urandom_range(0, 3) == 0);
          ic_in = 16'($urandom);
          nb_in = 4'($urandom);
          flush = 1'($urandom_range(0, 1));
        end
        @(negedge clk_sys);
        edges++;
      end
    end
    start = 1'b0; flush = 1'b0; mem_ok = 1'b0;
    if (!finished) check("done_never_seen", 32'd0, 32'd1);
    check("done_edges", 32'(edges), 32'(exp_edges));
    check("req_cycles", 32'(req_cycles), 32'(exp_req_cycles));
    check("wir_pulses", 32'(wir), 32'(exp_wir));
    check("ic_out", 32'(ic_out), 32'(exp_ic_out));
    check("alarm", 32'(alarm), 32'(exp_alarm));
    check("arg_valid", 32'(arg_valid), 32'(exp_av));
    if (exp_av) check("arg", 32'(arg), 32'(d1));
    check("req_at_done", 32'(mem_req), 32'd0);
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Returns the unit to a quiet IDLE; a stray mem_ok without a request must be ignored.
  task automatic idle_gap(input bit exp_alarm);
    @(negedge clk_sys);
`ifdef IFETCH_PREFETCH_EN
    flush = 1'b1;
    @(negedge clk_sys);
    flush = 1'b0;
`endif
    mem_ok = 1'b1; mem_data = 16'($urandom);
    @(negedge clk_sys);
    mem_ok = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_req", 32'(mem_req), 32'd0);
    check("idle_wir", 32'(w_ir), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_alarm", 32'(alarm), 32'(exp_alarm));
  endtask

  // ---------------- directed + random sequence ----------------
  logic [15:0] ic_r, d0_r;
  bit found;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; mem_ok = 1'b0;
    ic_in = '0; nb_in = '0; mem_data = '0;
    repeat (2) @(negedge clk_sys);
    check_zero("reset");
    check("reset_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;

    // One-word instruction, memory answers at once: done in cycle 4 (3 edges after start).
    do_fetch(16'h0100, 4'h3, 16'h4A05, 16'h0000, 0, 0, 1'b0);
`ifdef IFETCH_PREFETCH_EN
    @(negedge clk_sys);
    check("pf_req", 32'(mem_req), 32'd1);
    check("pf_addr", 32'(mem_addr), 32'h0101);
    mem_ok = 1'b1; mem_data = 16'h4A07;
    @(negedge clk_sys);
    mem_ok = 1'b0;
    check("pf_req_drop", 32'(mem_req), 32'd0);
    start = 1'b1; ic_in = 16'h0101; nb_in = 4'h3;
    @(negedge clk_sys);
    start = 1'b0;
    check("pf_hit_wir", 32'(w_ir), 32'd1);
    check("pf_hit_w", 32'(w), 32'h4A07);
    check("pf_hit_noreq", 32'(mem_req), 32'd0);
    @(negedge clk_sys);
    check("pf_hit_done", 32'(done), 32'd1);
    check("pf_hit_ic_out", 32'(ic_out), 32'h0102);
    idle_gap(1'b0);
    do_fetch(16'h0101, 4'h3, 16'h4A07, 16'h0000, 0, 0, 1'b0);
`endif
    idle_gap(1'b0);

    // Two-word instruction: argument from 0x0201, done in cycle 5.
    do_fetch(16'h0200, 4'h1, 16'h4A00, 16'h1234, 0, 0, 1'b0);
    idle_gap(1'b0);

    // Opcode never acknowledged: alarm after T request cycles, alarm holds in IDLE.
    do_fetch(16'h0400, 4'h2, 16'h4A05, 16'h0000, -1, 0, 1'b0);
    idle_gap(1'b1);

    // Counter wrap: argument read from 0x0000, ic_out 0x0001; also clears the previous alarm.
    do_fetch(16'hFFFF, 4'h7, 16'h1230, 16'hBEEF, 0, 0, 1'b0);
    idle_gap(1'b0);

    // Argument never acknowledged: IR strobe already issued, no argument, alarm.
    do_fetch(16'h0500, 4'h4, 16'h4A00, 16'h0000, 1, -1, 1'b0);
    idle_gap(1'b1);

    // Randomized fetches with wait states, stray starts/flushes and bus noise.
    for (int i = 0; i < 12; i++) begin
      ic_r = 16'($urandom);
      d0_r = 16'($urandom);
      if ($urandom_range(0, 1) == 1) d0_r[2:0] = 3'b000;
      do_fetch(ic_r, 4'($urandom), d0_r, 16'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
      idle_gap(1'b0);
    end

    // Reset in the middle of an argument request.
    @(negedge clk_sys);
    start = 1'b1; ic_in = 16'h0300; nb_in = 4'h5;
    @(negedge clk_sys);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_req && mem_addr == 16'h0301) begin
        found = 1'b1;
      end else begin
        mem_ok = mem_req; mem_data = 16'h4A00;
        @(negedge clk_sys);
      end
    end
    check("rst_reach_arg", 32'(found), 32'd1);
    check("rst_pre_state", 32'(dbg_state), 32'(S_FETCH_ARG));
    mem_ok = 1'b0; rst = 1'b1; start = 1'b1; ic_in = 16'h0777;
    @(negedge clk_sys);
    check_zero("midrst");
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0; start = 1'b0;
    @(negedge clk_sys);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_req", 32'(mem_req), 32'd0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
